inst_mem_server: RTL and testbench

Responder side of the instruction-fetch interface. It accepts one fetch request at a time over a valid/ready handshake and returns the 32-bit instruction word after a fixed latency. It flags misaligned or out-of-range addresses and supports a flush that abandons an in-flight request. A separate write port lets a program loader fill the memory. It sits between the fetch stage and on-chip instruction RAM.

---
 rtl/inst_mem_server.sv | 111 +++++++++++
 tb/tb_inst_mem_server.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_server.sv
// Instruction-fetch responder: single outstanding request, fixed-latency read of
// on-chip instruction RAM, address checking, flush, and a program-loader write port.
module inst_mem_server #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_inst_o,
  output logic        resp_err_o,
  input  logic        flush_i,
  input  logic        load_en_i,
  input  logic [63:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [63:0]        addr_q;
  logic [63:0]        rd_addr;
  logic               accept;
  logic               capture;
  logic               rd_err, ld_err;
  logic [IDX_W-1:0]   rd_idx, ld_idx;
  logic [31:0]        mem [DEPTH_WORDS];

  // Returns {err, word index}; index is meaningless when err is set.
  function automatic logic [IDX_W:0] decode(input logic [63:0] addr);
    logic [63:0] word;
    logic        err;
    word = (addr - BASE_ADDR) >> 2;
    err  = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || (word >= 64'(DEPTH_WORDS));
    return {err, word[IDX_W-1:0]};
  endfunction

  assign req_ready_o  = rst && !flush_i && (state == IDLE || (state == RESP && resp_ready_i));
  assign accept       = req_valid_i && req_ready_o;
  assign resp_valid_o = (state == RESP);

  // Capture from WAIT uses the latched address; a direct IDLE/RESP->RESP launch
  // (LATENCY==1) reads the address presented this cycle.
  assign rd_addr          = (state == WAIT) ? addr_q : req_addr_i;
  assign {rd_err, rd_idx} = decode(rd_addr);
  assign {ld_err, ld_idx} = decode(load_addr_i);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    if (resp_ready_i) state_nxt = IDLE;
      default: ;
    endcase
    if (accept) begin
      if (LATENCY == 1) begin
        state_nxt = RESP;
        capture   = 1'b1;
      end else begin
        state_nxt = WAIT;
        cnt_nxt   = 4'(LATENCY - 2);
      end
    end
    if (flush_i) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      resp_inst_o <= '0;
      resp_err_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) addr_q <= req_addr_i;
      if (capture) begin
        resp_inst_o <= rd_err ? NOP : mem[rd_idx];
        resp_err_o  <= rd_err;
      end
    end
  end

  // Separate write process gives read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (load_en_i && !ld_err) mem[ld_idx] <= load_data_i;
  end

endmodule

// File: tb/tb_inst_mem_server.sv
// Directed bench for inst_mem_server: scoreboarded responses plus cycle-exact
// latency, hold, flush, read-before-write and reset checks.
module tb_inst_mem_server;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, resp_ready, flush, load_en;
  logic [63:0] req_addr, load_addr;
  logic [31:0] load_data;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_inst;
  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [31:0] resp_inst_b;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_mem_server #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(64'h0)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_inst_o(resp_inst), .resp_err_o(resp_err),
    .flush_i(flush),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  inst_mem_server #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(64'h1000)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_b), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready),
    .resp_inst_o(resp_inst_b), .resp_err_o(resp_err_b),
    .flush_i(flush),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Starts and finishes in IDLE; response consumed in its first valid cycle.
  task automatic fetch(input logic [63:0] a, input logic [31:0] ei, input logic ee,
                       input bit chk_b, input logic [31:0] bi, input logic be);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
    #1 chk("fetch_ready", req_ready, 1);
    sb.push_back('{ei, ee});
    step();
    req_valid = 1'b0;
    #1 chk("fetch_wait_valid", resp_valid, 0);
    step();
    #1 chk("fetch_valid", resp_valid, 1);
    chk("fetch_inst", resp_inst, ei);
    chk("fetch_err", resp_err, ee);
    if (chk_b) begin
      chk("fetch_b_inst", resp_inst_b, bi);
      chk("fetch_b_err", resp_err_b, be);
    end
    step();
  endtask

  // Scoreboard consumer: every handshaken response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL stale_resp: observed=%h expected=none", resp_inst);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_inst", resp_inst, mon_e.inst);
        chk("sb_err", resp_err, mon_e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; flush = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) step();
    req_valid = 1'b1;
    #1 chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_inst", resp_inst, 0);
    chk("rst_err", resp_err, 0);
    req_valid = 1'b0;
    step();
    rst = 1'b1;

    load(64'h0, 32'h00500093);
    load(64'h4, 32'h00a00113);
    load(64'h8, 32'h11111111);
    load(64'hFFC, 32'hcafef00d);

    // Latency and hold with resp_ready low
    req_valid = 1'b1; req_addr = 64'h0; resp_ready = 1'b0;
    #1 chk("lat_ready", req_ready, 1);
    sb.push_back('{32'h00500093, 1'b0});
    step();
    req_valid = 1'b0;
    #1 chk("lat_wait_valid", resp_valid, 0);
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      #1 chk("hold_valid", resp_valid, 1);
      chk("hold_inst", resp_inst, 32'h00500093);
      chk("hold_ready", req_ready, 0);
      step();
    end
    // Release with a back-to-back request in the consuming cycle
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'h4;
    #1 chk("b2b_ready", req_ready, 1);
    sb.push_back('{32'h00a00113, 1'b0});
    step();
    req_valid = 1'b0;
    #1 chk("b2b_wait_valid", resp_valid, 0);
    step();
    #1 chk("b2b_valid", resp_valid, 1);
    chk("b2b_inst", resp_inst, 32'h00a00113);
    step();

    // Address errors and boundaries
    fetch(64'h2, NOP, 1'b1, 1'b0, '0, 1'b0);
    fetch(64'h1000, NOP, 1'b1, 1'b0, '0, 1'b0);
    fetch(64'hFFC, 32'hcafef00d, 1'b0, 1'b1, NOP, 1'b1);
    fetch(64'h2000, NOP, 1'b1, 1'b1, NOP, 1'b1);

    // Flush during WAIT, with a loader write in the flush cycle
    req_valid = 1'b1; req_addr = 64'h0; resp_ready = 1'b1;
    #1 chk("fw_accept_ready", req_ready, 1);
    step();
    req_addr = 64'h4; flush = 1'b1;
    load_en = 1'b1; load_addr = 64'hC; load_data = 32'h12345678;
    #1 chk("fw_flush_ready", req_ready, 0);
    step();
    flush = 1'b0; req_valid = 1'b0; load_en = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      #1 chk("fw_no_valid", resp_valid, 0);
      step();
    end

    // Flush during RESP, then earliest new accept
    req_valid = 1'b1; req_addr = 64'h4; resp_ready = 1'b0;
    #1 chk("fr_accept_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    step();
    #1 chk("fr_pre_valid", resp_valid, 1);
    flush = 1'b1; req_valid = 1'b1; req_addr = 64'h0;
    #1 chk("fr_flush_ready", req_ready, 0);
    step();
    flush = 1'b0; resp_ready = 1'b1;
    #1 chk("fr_post_valid", resp_valid, 0);
    chk("fr_post_ready", req_ready, 1);
    sb.push_back('{32'h00500093, 1'b0});
    step();
    req_valid = 1'b0;
    #1 chk("fr_wait_valid", resp_valid, 0);
    step();
    #1 chk("fr_valid", resp_valid, 1);
    chk("fr_inst", resp_inst, 32'h00500093);
    step();

    // Dropped loader writes leave memory intact; flush-cycle write landed
    load(64'hE, 32'hffffffff);
    load(64'h1000, 32'hffffffff);
    fetch(64'hC, 32'h12345678, 1'b0, 1'b0, '0, 1'b0);

    // Same-edge write and read of word 2: old data returned
    req_valid = 1'b1; req_addr = 64'h8; resp_ready = 1'b1;
    #1 chk("raw_ready", req_ready, 1);
    sb.push_back('{32'h11111111, 1'b0});
    step();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 64'h8; load_data = 32'hdeadbeef;
    step();
    load_en = 1'b0;
    #1 chk("raw_inst", resp_inst, 32'h11111111);
    step();
    fetch(64'h8, 32'hdeadbeef, 1'b0, 1'b0, '0, 1'b0);

    // Reset mid-WAIT
    req_valid = 1'b1; req_addr = 64'h4; resp_ready = 1'b1;
    #1 chk("rw_accept_ready", req_ready, 1);
    step();
    req_valid = 1'b0; rst = 1'b0;
    #1 chk("rw_ready_low", req_ready, 0);
    step();
    rst = 1'b1;
    #1 chk("rw_valid", resp_valid, 0);
    chk("rw_inst", resp_inst, 0);
    chk("rw_err", resp_err, 0);
    step();
    #1 chk("rw_no_stale", resp_valid, 0);
    fetch(64'h0, 32'h00500093, 1'b0, 1'b0, '0, 1'b0);
    fetch(64'h4, 32'h00a00113, 1'b0, 1'b0, '0, 1'b0);

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
